// File: rtl/des_byte_stream_if.sv
// Byte-stream handshake bundle for des_byte_stream: input frame bytes and output result bytes.
// The master modport is the stream source/sink side and the slave modport is the front end.
interface des_byte_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_is_key;
  logic       in_decrypt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, in_is_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_is_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/des_byte_stream.sv
// Byte-serial front end for a combinational DES core: assembles key/data frames, holds core inputs
// for SETTLE_CYCLES, captures the result and streams it out. Optional macro: DES_KEY_PARITY_CHECK_EN.
module des_byte_stream #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  des_byte_stream_if.slave    bus,
  output logic [63:0]         core_plain_text_o,
  output logic [63:0]         core_key_o,
  output logic                core_decrypt_o,
  input  logic [63:0]         core_cipher_text_i,
  output logic                key_loaded_o,
  output logic                err_nokey_o,
  output logic                key_err_o
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  settle_q, settle_d;
  logic [63:0] asm_q, asm_d;
  logic [63:0] shift_q, shift_d;
  logic [63:0] key_q, key_d;
  logic [63:0] pt_q, pt_d;
  logic        is_key_q, is_key_d;
  logic        dec_q, dec_d;
  logic        core_dec_q, core_dec_d;
  logic        key_loaded_q, key_loaded_d;
  logic        err_nokey_q, err_nokey_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        par_bad_q, par_bad_d;
  logic        key_err_q, key_err_d;
  logic        byte_even;
  assign byte_even = ~^bus.in_data;
`endif

  logic        in_accept;
  logic        out_accept;
  logic [63:0] frame_w;

  assign in_accept  = bus.in_valid & (state_q == S_LOAD);
  assign out_accept = out_valid_q & bus.out_ready;
  assign frame_w    = {asm_q[55:0], bus.in_data};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    asm_d        = asm_q;
    shift_d      = shift_q;
    key_d        = key_q;
    pt_d         = pt_q;
    is_key_d     = is_key_q;
    dec_d        = dec_q;
    core_dec_d   = core_dec_q;
    key_loaded_d = key_loaded_q;
    err_nokey_d  = 1'b0;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    par_bad_d    = par_bad_q;
    key_err_d    = 1'b0;
`endif

    case (state_q)
      S_LOAD: begin
        if (in_accept) begin
          asm_d = frame_w;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) begin
            is_key_d = bus.in_is_key;
            dec_d    = bus.in_decrypt;
          end
`ifdef DES_KEY_PARITY_CHECK_EN
          par_bad_d = ((cnt_q == 3'd0) ? 1'b0 : par_bad_q) | byte_even;
`endif
          if (cnt_q == 3'd7) begin
            if (is_key_q) begin
`ifdef DES_KEY_PARITY_CHECK_EN
              if (par_bad_q | byte_even) begin
                key_err_d = 1'b1;
              end else begin
                key_d        = frame_w;
                key_loaded_d = 1'b1;
              end
`else
              key_d        = frame_w;
              key_loaded_d = 1'b1;
`endif
            end else if (!key_loaded_q) begin
              err_nokey_d = 1'b1;
            end else begin
              pt_d       = frame_w;
              core_dec_d = dec_q;
              settle_d   = 4'd0;
              state_d    = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        // Core inputs have been stable for SETTLE_CYCLES once the counter reaches its last value.
        if (settle_q == SETTLE_LAST) begin
          shift_d     = core_cipher_text_i;
          cnt_d       = 3'd0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = S_SEND;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_SEND: begin
        if (out_accept) begin
          shift_d    = {shift_q[55:0], 8'h00};
          cnt_d      = cnt_q + 3'd1;
          out_last_d = (cnt_q == 3'd6);
          if (cnt_q == 3'd7) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: state uses non-blocking assignments under an asynchronous reset so every register updates together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= 3'd0;
      settle_q     <= 4'd0;
      asm_q        <= 64'h0;
      shift_q      <= 64'h0;
      key_q        <= 64'h0;
      pt_q         <= 64'h0;
      is_key_q     <= 1'b0;
      dec_q        <= 1'b0;
      core_dec_q   <= 1'b0;
      key_loaded_q <= 1'b0;
      err_nokey_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      par_bad_q    <= 1'b0;
      key_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      settle_q     <= settle_d;
      asm_q        <= asm_d;
      shift_q      <= shift_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      is_key_q     <= is_key_d;
      dec_q        <= dec_d;
      core_dec_q   <= core_dec_d;
      key_loaded_q <= key_loaded_d;
      err_nokey_q  <= err_nokey_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
`ifdef DES_KEY_PARITY_CHECK_EN
      par_bad_q    <= par_bad_d;
      key_err_q    <= key_err_d;
`endif
    end
  end

  assign bus.in_ready      = (state_q == S_LOAD);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = shift_q[63:56];
  assign bus.out_last      = out_last_q;
  assign core_plain_text_o = pt_q;
  assign core_key_o        = key_q;
  assign core_decrypt_o    = core_dec_q;
  assign key_loaded_o      = key_loaded_q;
  assign err_nokey_o       = err_nokey_q;
`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_err_o         = key_err_q;
`else
  assign key_err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_des_byte_stream.sv
// Self-checking bench for des_byte_stream: directed vectors plus randomized frames against a
// frame-level model; a stand-in core maps the known DES vector and uses a reversible mix otherwise.
module tb_des_byte_stream;
  localparam int          SETTLE = 2;
  localparam logic [63:0] KV = 64'h133457799BBCDFF1;
  localparam logic [63:0] PV = 64'h0123456789ABCDEF;
  localparam logic [63:0] CV = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] core_pt, core_key, core_ct;
  logic        core_dec, key_loaded, err_nokey, key_err;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] m_key = 64'h0;
  bit          m_loaded = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_byte_stream_if bus();

  des_byte_stream #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .core_plain_text_o  (core_pt),
    .core_key_o         (core_key),
    .core_decrypt_o     (core_dec),
    .core_cipher_text_i (core_ct),
    .key_loaded_o       (key_loaded),
    .err_nokey_o        (err_nokey),
    .key_err_o          (key_err)
  );

  // Stand-in for the combinational DES core: exact on the reference vector, reversible mix elsewhere.
  function automatic logic [63:0] core_fn(input logic [63:0] pt, input logic [63:0] k, input logic dec);
    logic [63:0] x;
    if (k == KV && !dec && pt == PV) return CV;
    if (k == KV && dec && pt == CV) return PV;
    if (dec) begin
      x = {pt[12:0], pt[63:13]};
      return x ^ k;
    end
    x = pt ^ k;
    return {x[50:0], x[63:51]};
  endfunction

  assign core_ct = core_fn(core_pt, core_key, core_dec);

  function automatic bit key_parity_ok(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if (!(^k[8*b +: 8])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] make_odd(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+1 +: 7];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the edge that took byte 7.
  task automatic send_frame(input logic [63:0] v, input bit is_key, input bit dec, input bit gaps,
                            output int n_edge);
    int t;
    n_edge = 0;
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid   = 1'b1;
      bus.in_data    = v[63-8*i -: 8];
      bus.in_is_key  = (i == 0) ? is_key : 1'($urandom_range(0, 1));
      bus.in_decrypt = (i == 0) ? dec : 1'($urandom_range(0, 1));
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t == 50) begin
        check("in_ready_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 n_edge = cyc;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_flags(input bit exp_nokey, input bit exp_keyerr);
    check("err_nokey", err_nokey, exp_nokey);
    check("key_err", key_err, exp_keyerr);
    @(negedge clk);
    check("err_nokey_clr", err_nokey, 0);
    check("key_err_clr", key_err, 0);
  endtask

  task automatic recv_block(input logic [63:0] exp, input int stall_at, input int n_edge, input bit rnd);
    int t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    if (!bus.out_valid) return;
    check("latency", cyc - n_edge, SETTLE);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_data", bus.out_data, exp[63-8*i -: 8]);
          check("stall_valid", bus.out_valid, 1);
        end
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        bus.out_ready = 1'b0;
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
      check($sformatf("out_valid%0d", i), bus.out_valid, 1);
      check($sformatf("out_byte%0d", i), bus.out_data, exp[63-8*i -: 8]);
      check($sformatf("out_last%0d", i), bus.out_last, (i == 7));
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic expect_idle(input string tag);
    bit seen = 1'b0;
    bit rdy = 1'b1;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.out_valid;
      rdy  &= bus.in_ready;
    end
    check({tag, "_no_out_valid"}, seen, 0);
    check({tag, "_in_ready"}, rdy, 1);
  endtask

  task automatic do_key(input logic [63:0] k, input bit gaps);
    int  n;
    bit  ok;
`ifdef DES_KEY_PARITY_CHECK_EN
    ok = key_parity_ok(k);
`else
    ok = 1'b1;
`endif
    send_frame(k, 1'b1, 1'($urandom_range(0, 1)), gaps, n);
    if (ok) begin
      m_key    = k;
      m_loaded = 1'b1;
    end
    check("key_loaded", key_loaded, m_loaded);
    check("core_key", core_key, m_key);
    check_flags(1'b0, !ok);
  endtask

  task automatic do_data(input logic [63:0] d, input bit dec, input int stall_at, input bit rnd);
    int n;
    send_frame(d, 1'b0, dec, rnd, n);
    if (m_loaded) begin
      check("in_ready_wait", bus.in_ready, 0);
      check("core_pt", core_pt, d);
      check("core_dec", core_dec, dec);
      check_flags(1'b0, 1'b0);
      recv_block(core_fn(d, m_key, dec), stall_at, n, rnd);
    end else begin
      check_flags(1'b1, 1'b0);
      expect_idle("nokey");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    int n;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_is_key  = 1'b0;
    bus.in_decrypt = 1'b0;
    bus.out_ready  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_err_nokey", err_nokey, 0);
    check("rst_key_err", key_err, 0);
    check("rst_core_dec", core_dec, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_pt", core_pt, 0);
    @(negedge clk);

    do_data(64'h0001020304050607, 1'b0, -1, 1'b0);

`ifdef DES_KEY_PARITY_CHECK_EN
    do_key(64'h123457799BBCDFF1, 1'b0);
    check("parity_reject_kl", key_loaded, 0);
`endif

    do_key(KV, 1'b0);
    do_data(PV, 1'b0, 3, 1'b0);
    do_data(CV, 1'b1, -1, 1'b0);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        k = {$urandom, $urandom};
`ifdef DES_KEY_PARITY_CHECK_EN
        if ($urandom_range(0, 3) != 0) k = make_odd(k);
`endif
        do_key(k, 1'b1);
      end else begin
        do_data({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, 1'b1);
      end
    end

    do_key(KV, 1'b0);
    send_frame(PV, 1'b0, 1'b0, 1'b0, n);
    check("mid_in_ready_wait", bus.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_loaded = 1'b0;
    m_key    = 64'h0;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_key_loaded", key_loaded, 0);
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_core_key", core_key, 0);
    @(negedge clk);
    do_data(PV, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/des_byte_stream.md
# des_byte_stream

Byte-serial front end for the combinational DES core. Assembles 8-byte key and data frames from a valid/ready byte stream and drives the core's plain-text, key and encrypt/decrypt inputs. Holds them stable for a programmable settle window, captures the core's 64-bit result, and streams it back out as 8 bytes. Sits directly upstream of and around the core, so the combinational core can be treated as a multicycle path.

## Interface
- SETTLE_CYCLES, 2: cycles the core inputs are held before the result is captured; legal range 1..15.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte ready.
- in_data  in  8  input byte.
- in_is_key  in  1  frame type; sampled on the first byte of a frame only (1 = key frame, 0 = data frame).
- in_decrypt  in  1  mode for a data frame; sampled on the first byte of a frame (0 = encrypt, 1 = decrypt).
- out_valid  out  1  result byte valid.
- out_ready  in  1  result byte accepted.
- out_data  out  8  result byte.
- out_last  out  1  high with the 8th result byte.
- core_plain_text  out  64  to core plain-text input.
- core_key  out  64  to core key input; parity bits are not dropped.
- core_decrypt  out  1  to core encrypt/decrypt input.
- core_cipher_text  in  64  from core output.
- key_loaded  out  1  a valid key is held.
- err_nokey  out  1  one-cycle pulse: a data frame was dropped because no key is held.
- key_err  out  1  one-cycle pulse: a key frame was rejected for parity (see Configuration).

## Operation
- Byte order is MSB first. Frame byte 0 maps to [63:56] and byte 7 to [7:0], for input and output alike.
- There are three FSM states.
- S_LOAD
  - in_ready = 1.
  - A byte is accepted on in_valid & in_ready.
  - A 3-bit counter counts the frame's bytes.
  - Frame type and mode are latched on byte 0.
  - Bytes shift into a 64-bit assembly register.
- Key frame
  - On byte 7, core_key is loaded and key_loaded is set. The state stays S_LOAD and no output is produced.
  - A new key frame overwrites the key at any time.
- Data frame with key_loaded = 0
  - All 8 bytes are consumed and discarded.
  - err_nokey pulses in the cycle after byte 7. The state stays S_LOAD.
- Data frame with key_loaded = 1
  - On byte 7, core_plain_text and core_decrypt are loaded, and the state goes to S_WAIT.
- S_WAIT
  - in_ready = 0.
  - The settle counter runs SETTLE_CYCLES cycles.
  - On the last cycle, core_cipher_text is captured into the output shift register and the state goes to S_SEND.
- S_SEND
  - out_valid = 1. out_data is the top byte of the shift register.
  - On out_valid & out_ready, the register shifts left 8 and the counter increments.
  - out_last = 1 while the counter = 7. Its handshake returns the state to S_LOAD.
- core_key, core_plain_text and core_decrypt change only at the load points above, so they are stable throughout S_WAIT.
- Mid-frame changes of in_is_key or in_decrypt are ignored.
- out_valid stays high with the same data while out_ready = 0.

## Timing
- Reset values:
  - state S_LOAD, so in_ready = 1 during and after reset.
  - out_valid, out_last, out_data, key_loaded, err_nokey, key_err, core_decrypt, counters: 0.
  - core_key, core_plain_text and shift registers: 64'h0.
- in_ready is combinational from state. All other outputs are registered.
- Latency: the 8th data byte is accepted at edge N. The result is captured at edge N+SETTLE_CYCLES, and out_valid is first high after that edge.
- Best-case throughput is 8 + SETTLE_CYCLES + 8 cycles per block.
- No overlap: input is not accepted in S_WAIT or S_SEND.
- A key frame does not disturb the result of a block already in S_WAIT or S_SEND, because the block's key was loaded earlier.
- rst asserted mid-frame, in S_WAIT or in S_SEND:
  - the partial frame and any pending result are discarded;
  - key_loaded clears, so a key frame is required before the next data frame.

## Configuration
- DES_KEY_PARITY_CHECK_EN defined:
  - Each key byte is checked for odd parity as it is accepted.
  - If any byte is even, the key frame completes (all 8 bytes are consumed) but core_key and key_loaded are unchanged.
  - key_err pulses for one cycle after byte 7.
- DES_KEY_PARITY_CHECK_EN undefined: parity is ignored, every key frame loads, and key_err is tied 0.

## Test plan
- Encrypt, known vector:
  - Stimulus: key frame 13 34 57 79 9B BC DF F1, then data frame 01 23 45 67 89 AB CD EF with in_decrypt = 0.
  - Required: key_loaded = 1; out bytes 85 E8 13 54 0F 0A B4 05, with out_last on 05.
  - Required: first out_valid at edge N+SETTLE_CYCLES.
- Decrypt: same key, data 85 E8 13 54 0F 0A B4 05 with in_decrypt = 1 → out 01 23 45 67 89 AB CD EF.
- No key: after reset, send data frame 00..07.
  - Required: err_nokey is a single-cycle pulse, there is no out_valid, and in_ready stays 1.
- Backpressure: hold out_ready = 0 for 5 cycles at byte 3 of the output.
  - Required: out_data stays at that byte, out_valid stays 1, and no bytes are lost or duplicated.
- Parity (macro defined): send key 12 34 57 79 9B BC DF F1 (byte 0 even).
  - Required: key_err pulses and key_loaded stays 0.
  - Required: the following valid key plus vector still gives 85E813540F0AB405.
- Reset mid-op: assert rst during S_WAIT.
  - Required: out_valid = 0, key_loaded = 0, in_ready = 1 after release.
  - Required: the next data frame produces err_nokey.
